sram_arbiter: RTL and testbench

Two-port arbiter that shares the single external-SRAM controller between the pipeline memory stage (port 0) and a secondary requester such as a DMA or debug loader (port 1). It latches one request at a time, drives the controller's enable/address/data inputs and waits for its ready. It then returns read data and a one-cycle done pulse to the winning port. It sits between the requesters and the SRAM controller; the controller keeps ownership of the SRAM pins.

---
 rtl/sram_arbiter_if.sv | 44 ++++
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface sram_arbiter_if;
    logic        p0_read_en;
    logic        p0_write_en;
    logic [31:0] p0_address;
    logic [31:0] p0_write_data;
    logic        p0_done;
    logic [31:0] p0_read_data;
    logic        p0_busy;

    logic        p1_read_en;
    logic        p1_write_en;
    logic [31:0] p1_address;
    logic [31:0] p1_write_data;
    logic        p1_done;
    logic [31:0] p1_read_data;
    logic        p1_busy;

    logic        sram_read_en;
    logic        sram_write_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic        sram_ready;
    logic [31:0] sram_read_data;

    modport slave (
        input  p0_read_en, p0_write_en, p0_address, p0_write_data,
        input  p1_read_en, p1_write_en, p1_address, p1_write_data,
        input  sram_ready, sram_read_data,
        output p0_done, p0_read_data, p0_busy,
        output p1_done, p1_read_data, p1_busy,
        output sram_read_en, sram_write_en, sram_address, sram_write_data
    );

    modport master (
        output p0_read_en, p0_write_en, p0_address, p0_write_data,
        output p1_read_en, p1_write_en, p1_address, p1_write_data,
        output sram_ready, sram_read_data,
        input  p0_done, p0_read_data, p0_busy,
        input  p1_done, p1_read_data, p1_busy,
        input  sram_read_en, sram_write_en, sram_address, sram_write_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: latches one request,
// runs it through START/WAIT, then pulses done and returns read data to the winner.
module sram_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic                   op_read_q, op_read_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic [1:0]             done_q, done_d;
    logic [1:0][DW-1:0]     rdata_q, rdata_d;

    logic                   req0_c, req1_c, win_c, win_read_c;

    // Arbitration: a lone requester wins; a tie goes by priority mode.
    always_comb begin
        req0_c = bus.p0_read_en | bus.p0_write_en;
        req1_c = bus.p1_read_en | bus.p1_write_en;
        win_c  = 1'b0;
        if (req0_c && req1_c) begin
            win_c = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else if (req1_c) begin
            win_c = 1'b1;
        end
        win_read_c = win_c ? bus.p1_read_en : bus.p0_read_en;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_read_d    = op_read_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        rdata_d      = rdata_q;
        done_d       = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (req0_c || req1_c) begin
                    grant_d      = win_c;
                    last_grant_d = win_c;
                    op_read_d    = win_read_c;
                    addr_d       = win_c ? bus.p1_address    : bus.p0_address;
                    wdata_d      = win_c ? bus.p1_write_data : bus.p0_write_data;
                    rd_en_d      = win_read_c;
                    wr_en_d      = ~win_read_c;
                    state_d      = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.sram_ready) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    if (op_read_q) begin
                        rdata_d[grant_q] = bus.sram_read_data;
                    end
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_read_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            done_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_read_q    <= op_read_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.sram_read_en    = rd_en_q;
    assign bus.sram_write_en   = wr_en_q;
    assign bus.sram_address    = addr_q;
    assign bus.sram_write_data = wdata_q;
    assign bus.p0_done         = done_q[0];
    assign bus.p1_done         = done_q[1];
    assign bus.p0_read_data    = rdata_q[0];
    assign bus.p1_read_data    = rdata_q[1];
    // Stall drops in the done cycle so the pipeline advances exactly once.
    assign bus.p0_busy         = (bus.p0_read_en | bus.p0_write_en) & ~done_q[0];
    assign bus.p1_busy         = (bus.p1_read_en | bus.p1_write_en) & ~done_q[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter see identical
// stimulus and a shared controller model; a negedge monitor checks every done.
module tb_sram_arbiter;
    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        p0_re = 1'b0, p0_we = 1'b0, p1_re = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p1_addr = '0, p0_wd = '0, p1_wd = '0;

    // Controller model: ready pulses in the (lat+1)-th cycle a command is high.
    int          lat = 6;
    int          cnt = 0;
    logic        ready = 1'b0;
    logic [31:0] nrdy = '0;
    logic [31:0] rd_val = '0;
    logic        cmd_c;

    exp_t        sb_rr[$];
    exp_t        sb_fp[$];
    logic [31:0] model_rd [2][2];

    sram_arbiter_if bus_rr();
    sram_arbiter_if bus_fp();

    sram_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    sram_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    assign bus_rr.p0_read_en = p0_re;   assign bus_fp.p0_read_en = p0_re;
    assign bus_rr.p0_write_en = p0_we;  assign bus_fp.p0_write_en = p0_we;
    assign bus_rr.p0_address = p0_addr; assign bus_fp.p0_address = p0_addr;
    assign bus_rr.p0_write_data = p0_wd; assign bus_fp.p0_write_data = p0_wd;
    assign bus_rr.p1_read_en = p1_re;   assign bus_fp.p1_read_en = p1_re;
    assign bus_rr.p1_write_en = p1_we;  assign bus_fp.p1_write_en = p1_we;
    assign bus_rr.p1_address = p1_addr; assign bus_fp.p1_address = p1_addr;
    assign bus_rr.p1_write_data = p1_wd; assign bus_fp.p1_write_data = p1_wd;
    assign bus_rr.sram_ready = ready;   assign bus_fp.sram_ready = ready;
    assign bus_rr.sram_read_data = ready ? rd_val + nrdy : 32'h0;
    assign bus_fp.sram_read_data = ready ? rd_val + nrdy : 32'h0;
    assign cmd_c = bus_rr.sram_read_en | bus_rr.sram_write_en;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            cnt   <= 0;
            ready <= 1'b0;
        end else if (cmd_c) begin
            cnt   <= cnt + 1;
            ready <= (cnt + 1 == lat);
        end else begin
            cnt   <= 0;
            ready <= 1'b0;
        end
        if (ready) nrdy <= nrdy + 32'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc=%0d: got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input int p, input bit rd, input logic [31:0] data, input int c);
        exp_t e;
        if (rd) model_rd[d][p] = data;
        e.port = p;
        e.data = model_rd[d][p];
        e.cyc  = c;
        if (d == 0) sb_rr.push_back(e);
        else        sb_fp.push_back(e);
    endtask

    task automatic push_both(input int p, input bit rd, input logic [31:0] data, input int c);
        push(0, p, rd, data, c);
        push(1, p, rd, data, c);
    endtask

    task automatic mon(input int d, input logic dn0, input logic dn1,
                       input logic [31:0] rd0, input logic [31:0] rd1);
        exp_t e;
        int   sz;
        if (dn0 | dn1) chk("done_overlap", 32'(dn0 & dn1), 32'h0);
        for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? dn0 : dn1) begin
                sz = (d == 0) ? sb_rr.size() : sb_fp.size();
                if (sz == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done dut=%0d port=%0d cyc=%0d", d, p, cyc);
                end else begin
                    if (d == 0) e = sb_rr.pop_front();
                    else        e = sb_fp.pop_front();
                    chk($sformatf("done_port_d%0d", d), 32'(p), 32'(e.port));
                    chk($sformatf("read_data_d%0d", d), (p == 0) ? rd0 : rd1, e.data);
                    chk($sformatf("done_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_rr.p0_done, bus_rr.p1_done, bus_rr.p0_read_data, bus_rr.p1_read_data);
        mon(1, bus_fp.p0_done, bus_fp.p1_done, bus_fp.p0_read_data, bus_fp.p1_read_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          c0;
        logic [31:0] n0;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) model_rd[d][p] = '0;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", 32'(bus_rr.sram_read_en), 32'h0);
        chk("rst_wr_en", 32'(bus_rr.sram_write_en), 32'h0);
        chk("rst_addr", bus_rr.sram_address, 32'h0);
        chk("rst_wdata", bus_rr.sram_write_data, 32'h0);
        chk("rst_rdata", bus_rr.p0_read_data | bus_rr.p1_read_data, 32'h0);
        chk("rst_done", 32'({bus_rr.p0_done, bus_rr.p1_done}), 32'h0);
        step();

        // Single read on port 0
        c0 = cyc;
        p0_addr = 32'h400; p0_re = 1'b1;
        rd_val = 32'hDEADBEEF - nrdy;
        push_both(0, 1'b1, 32'hDEADBEEF, c0 + 8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t1_rd_en", 32'(bus_rr.sram_read_en), 32'(k >= 1 && k <= 7));
            if (k == 3) chk("t1_addr", bus_rr.sram_address, 32'h400);
            if (k == 3) chk("t1_busy", 32'(bus_rr.p0_busy), 32'h1);
            if (k == 8) chk("t1_busy_done", 32'(bus_rr.p0_busy), 32'h0);
            if (k == 8) chk("t1_p1_rdata", bus_rr.p1_read_data, 32'h0);
            if (k == 8) chk("t1_p1_done", 32'(bus_rr.p1_done), 32'h0);
            step();
            if (k == 8) p0_re = 1'b0;
        end

        // Single write on port 1
        c0 = cyc;
        p1_addr = 32'h404; p1_wd = 32'h12345678; p1_we = 1'b1;
        push_both(1, 1'b0, 32'h0, c0 + 8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_wr_en", 32'(bus_rr.sram_write_en), 32'(k >= 1 && k <= 7));
            chk("t2_rd_en", 32'(bus_rr.sram_read_en), 32'h0);
            if (k >= 1 && k <= 7) chk("t2_wdata", bus_rr.sram_write_data, 32'h12345678);
            if (k == 4) chk("t2_addr", bus_rr.sram_address, 32'h404);
            step();
            if (k == 8) p1_we = 1'b0;
        end

        // Both ports read continuously: alternate vs. port 0 always wins
        c0 = cyc;
        n0 = nrdy;
        rd_val = 32'hA0000000;
        p0_addr = 32'h10; p1_addr = 32'h20; p0_re = 1'b1; p1_re = 1'b1;
        push(0, 0, 1'b1, rd_val + n0,         c0 + 8);
        push(0, 1, 1'b1, rd_val + n0 + 32'd1, c0 + 17);
        push(0, 0, 1'b1, rd_val + n0 + 32'd2, c0 + 26);
        push(1, 0, 1'b1, rd_val + n0,         c0 + 8);
        push(1, 0, 1'b1, rd_val + n0 + 32'd1, c0 + 17);
        push(1, 0, 1'b1, rd_val + n0 + 32'd2, c0 + 26);
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (k == 12) chk("t3_rr_addr_p1", bus_rr.sram_address, 32'h20);
            if (k == 12) chk("t3_fp_addr_p0", bus_fp.sram_address, 32'h10);
            if (k == 26) chk("t3_fp_p1_starved", 32'(bus_fp.p1_busy), 32'h1);
            step();
            if (k == 26) begin p0_re = 1'b0; p1_re = 1'b0; end
        end

        // Slow controller: arbiter waits as long as ready stays low
        lat = 10;
        c0 = cyc;
        n0 = nrdy;
        rd_val = 32'h5A5A0000;
        p1_addr = 32'h30; p1_re = 1'b1;
        push_both(1, 1'b1, rd_val + n0, c0 + 12);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 10) chk("t4_rd_en_long", 32'(bus_rr.sram_read_en), 32'h1);
            step();
            if (k == 12) p1_re = 1'b0;
        end
        lat = 6;

        // Read wins over write on one port; address change mid-WAIT is ignored
        c0 = cyc;
        n0 = nrdy;
        rd_val = 32'h0BADC0DE;
        p0_addr = 32'h500; p0_wd = 32'hCAFEF00D; p0_re = 1'b1; p0_we = 1'b1;
        push_both(0, 1'b1, rd_val + n0, c0 + 8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_wr_en", 32'(bus_rr.sram_write_en), 32'h0);
            chk("t5_rd_en", 32'(bus_rr.sram_read_en), 32'(k >= 1 && k <= 7));
            if (k == 5) chk("t5_addr_latched", bus_rr.sram_address, 32'h500);
            step();
            if (k == 2) p0_addr = 32'h800;
            if (k == 8) begin p0_re = 1'b0; p0_we = 1'b0; end
        end

        // Reset in cycle 4 aborts; held request then completes normally
        c0 = cyc;
        n0 = nrdy;
        rd_val = 32'h77770000;
        p0_addr = 32'h600; p0_re = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 4) chk("t6_rd_en_pre", 32'(bus_rr.sram_read_en), 32'h1);
            if (k == 5) begin
                chk("t6_rd_en_post", 32'(bus_rr.sram_read_en), 32'h0);
                chk("t6_done_post", 32'({bus_rr.p0_done, bus_rr.p1_done, bus_fp.p0_done, bus_fp.p1_done}), 32'h0);
                chk("t6_rdata_rr", bus_rr.p0_read_data | bus_rr.p1_read_data, 32'h0);
                chk("t6_rdata_fp", bus_fp.p0_read_data | bus_fp.p1_read_data, 32'h0);
            end
            step();
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) model_rd[d][p] = '0;
                push_both(0, 1'b1, rd_val + n0, c0 + 13);
            end
            if (k == 13) p0_re = 1'b0;
        end

        repeat (3) step();
        chk("sb_rr_empty", 32'(sb_rr.size()), 32'h0);
        chk("sb_fp_empty", 32'(sb_fp.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
